// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the on-chip SRAM master/slave pair:
// FSM states, burst and response encodings, and response merging.
package axi4_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_8B = 3'b011;

  // Worst-of merge: the encodings are ordered by severity.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_beat_cnt.sv
// Beat counter shared by the R and W paths; last is high while the
// current beat index equals len, so len=255 yields 256 beats.
module axi4_beat_cnt
  import axi4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] len,
  output logic       last
);

  logic [7:0] cnt;

  // Beat index register, cleared per command and on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign last = (cnt == len);

endmodule

// File: rtl/sram_master.sv
// AXI4 master issuing one read or write burst at a time on behalf of a
// local requester; data beats pass straight through with no added latency.
module sram_master
  import axi4_pkg::*;
#(
  parameter int         DATA_W = 64,
  parameter int         ADDR_W = 8,
  parameter logic [3:0] ID     = 4'd0
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_W-1:0]     i_cmd_addr,
  input  logic [7:0]            i_cmd_len,
  input  logic [1:0]            i_cmd_burst,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic [DATA_W/8-1:0]   i_wr_strb,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_rd_last,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic                  o_done,
  output logic [1:0]            o_resp,
  output logic [3:0]            o_arid,
  output logic [ADDR_W-1:0]     o_araddr,
  output logic [7:0]            o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  output logic                  o_arlock,
  output logic [3:0]            o_arcache,
  output logic [2:0]            o_arprot,
  output logic [3:0]            o_arqos,
  output logic [3:0]            o_arregion,
  output logic                  o_aruser,
  output logic [3:0]            o_awid,
  output logic [ADDR_W-1:0]     o_awaddr,
  output logic [7:0]            o_awlen,
  output logic [2:0]            o_awsize,
  output logic [1:0]            o_awburst,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic                  o_awlock,
  output logic [3:0]            o_awcache,
  output logic [2:0]            o_awprot,
  output logic [3:0]            o_awqos,
  output logic [3:0]            o_awregion,
  output logic                  o_awuser,
  input  logic [3:0]            i_rid,
  input  logic [DATA_W-1:0]     i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  output logic [DATA_W-1:0]     o_wdata,
  output logic [DATA_W/8-1:0]   o_wstrb,
  output logic                  o_wlast,
  output logic                  o_wvalid,
  output logic                  o_wuser,
  input  logic                  i_wready,
  input  logic [3:0]            i_bid,
  input  logic [1:0]            i_bresp,
  input  logic                  i_bvalid,
  output logic                  o_bready
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] ar_addr, aw_addr;
  logic [7:0]        ar_len, aw_len;
  logic [1:0]        ar_burst, aw_burst;
  logic [1:0]        resp, resp_next;
  logic              done, done_next;
  logic              cmd_hs, r_hs, w_hs, b_hs, beat_last;
  logic [7:0]        beat_len;

  assign cmd_hs   = (state == S_IDLE) && i_cmd_valid;
  assign r_hs     = (state == S_R) && i_rvalid && i_rd_ready;
  assign w_hs     = (state == S_W) && i_wr_valid && i_wready;
  assign b_hs     = (state == S_B) && i_bvalid;
  assign beat_len = (state == S_W) ? aw_len : ar_len;

  axi4_beat_cnt u_beat_cnt (
    .clk  (i_aclk),
    .rst  (i_areset),
    .clr  (cmd_hs),
    .inc  (r_hs || w_hs),
    .len  (beat_len),
    .last (beat_last)
  );

  // State, latched command fields, accumulated response and done pulse.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      state    <= S_IDLE;
      ar_addr  <= '0;
      ar_len   <= 8'd0;
      ar_burst <= 2'd0;
      aw_addr  <= '0;
      aw_len   <= 8'd0;
      aw_burst <= 2'd0;
      resp     <= RESP_OKAY;
      done     <= 1'b0;
    end else begin
      state <= state_next;
      resp  <= resp_next;
      done  <= done_next;
      if (cmd_hs && i_cmd_write) begin
        aw_addr  <= i_cmd_addr;
        aw_len   <= i_cmd_len;
        aw_burst <= i_cmd_burst;
      end else if (cmd_hs) begin
        ar_addr  <= i_cmd_addr;
        ar_len   <= i_cmd_len;
        ar_burst <= i_cmd_burst;
      end
    end
  end

  // Next-state and completion decode.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          state_next = i_cmd_write ? S_AW : S_AR;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_AR: begin
        if (i_arready) state_next = S_R;
        else           state_next = S_AR;
      end
      S_AW: begin
        if (i_awready) state_next = S_W;
        else           state_next = S_AW;
      end
      S_R: begin
        // An early or missing RLAST still closes the burst, flagged via resp.
        if (r_hs && (i_rlast || beat_last)) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = S_R;
        end
      end
      S_W: begin
        if (w_hs && beat_last) state_next = S_B;
        else                   state_next = S_W;
      end
      S_B: begin
        if (i_bvalid) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = S_B;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Worst response of the burst, restarted by each accepted command.
  always_comb begin
    resp_next = resp;
    if (cmd_hs) begin
      resp_next = RESP_OKAY;
    end else if (r_hs) begin
      resp_next = resp_max(resp, i_rresp);
      if ((i_rid != ID) || (i_rlast != beat_last)) begin
        resp_next = resp_max(resp_next, RESP_SLVERR);
      end else begin
        resp_next = resp_max(resp_next, RESP_OKAY);
      end
    end else if (b_hs) begin
      resp_next = resp_max(resp, i_bresp);
      if (i_bid != ID) begin
        resp_next = resp_max(resp_next, RESP_SLVERR);
      end else begin
        resp_next = resp_max(resp_next, RESP_OKAY);
      end
    end else begin
      resp_next = resp;
    end
  end

  assign o_cmd_ready = (state == S_IDLE);
  assign o_done      = done;
  assign o_resp      = resp;

  assign o_arid      = ID;
  assign o_araddr    = ar_addr;
  assign o_arlen     = ar_len;
  assign o_arsize    = SIZE_8B;
  assign o_arburst   = ar_burst;
  assign o_arvalid   = (state == S_AR);
  assign o_arlock    = 1'b0;
  assign o_arcache   = 4'd0;
  assign o_arprot    = 3'd0;
  assign o_arqos     = 4'd0;
  assign o_arregion  = 4'd0;
  assign o_aruser    = 1'b0;

  assign o_awid      = ID;
  assign o_awaddr    = aw_addr;
  assign o_awlen     = aw_len;
  assign o_awsize    = SIZE_8B;
  assign o_awburst   = aw_burst;
  assign o_awvalid   = (state == S_AW);
  assign o_awlock    = 1'b0;
  assign o_awcache   = 4'd0;
  assign o_awprot    = 3'd0;
  assign o_awqos     = 4'd0;
  assign o_awregion  = 4'd0;
  assign o_awuser    = 1'b0;

  assign o_rready    = (state == S_R) && i_rd_ready;
  assign o_rd_valid  = (state == S_R) && i_rvalid;
  assign o_rd_data   = (state == S_R) ? i_rdata : '0;
  assign o_rd_last   = (state == S_R) && beat_last;

  assign o_wvalid    = (state == S_W) && i_wr_valid;
  assign o_wr_ready  = (state == S_W) && i_wready;
  assign o_wdata     = (state == S_W) ? i_wr_data : '0;
  assign o_wstrb     = (state == S_W) ? i_wr_strb : '0;
  assign o_wlast     = (state == S_W) && beat_last;
  assign o_wuser     = 1'b0;

  assign o_bready    = (state == S_B);

endmodule
